// File: rtl/pe_pkg.sv
// Shared constants for the PE operand feeder: default datapath width and
// FSM state encodings.
package pe_pkg;

   localparam int PE_DATA_W = 16;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_CLEAR  = 3'd1;
   localparam logic [2:0] ST_STREAM = 3'd2;
   localparam logic [2:0] ST_DRAIN  = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/pe_pair_rf.sv
// Register file of (ifmap, filter) operand pairs: one write port, one
// combinational read port, asynchronously cleared to zero.
module pe_pair_rf #(
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [ADDR_W-1:0] waddr_i,
   input  logic [DATA_W-1:0] wifmap_i,
   input  logic [DATA_W-1:0] wfilter_i,
   input  logic [ADDR_W-1:0] raddr_i,
   output logic [DATA_W-1:0] rifmap_o,
   output logic [DATA_W-1:0] rfilter_o
);

   logic [2*DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we_i) begin
         mem_q[waddr_i] <= {wifmap_i, wfilter_i};
      end
   end

   assign rifmap_o  = mem_q[raddr_i][2*DATA_W-1:DATA_W];
   assign rfilter_o = mem_q[raddr_i][DATA_W-1:0];

endmodule

// File: rtl/pe_feeder.sv
// Operand feeder for the pe MAC element: stores pairs, clears the PE, streams
// the pairs under pe_en and returns the accumulated psum over valid/ready.
module pe_feeder
   import pe_pkg::*;
#(
   parameter int DATA_W = PE_DATA_W,
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_ifmap,
   input  logic [DATA_W-1:0] wr_filter,
   input  logic [ADDR_W:0]   len,
   input  logic              start,
   output logic              busy,
   output logic              pe_rst,
   output logic              pe_en,
   output logic [DATA_W-1:0] pe_ifmap,
   output logic [DATA_W-1:0] pe_filter,
   input  logic [DATA_W-1:0] pe_psum,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_data
);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W:0]   len_q, len_d;
   logic [ADDR_W:0]   idx_q, idx_d;
   logic              busy_q, busy_d;
   logic              pe_rst_q, pe_rst_d;
   logic              pe_en_q, pe_en_d;
   logic [DATA_W-1:0] pe_ifmap_q, pe_ifmap_d;
   logic [DATA_W-1:0] pe_filter_q, pe_filter_d;
   logic              res_valid_q, res_valid_d;
   logic [DATA_W-1:0] res_data_q, res_data_d;

   logic              rf_we;
   logic [DATA_W-1:0] rd_ifmap, rd_filter;
   logic [ADDR_W:0]   len_clamped;

   function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] l);
      if (int'(l) > DEPTH) return (ADDR_W+1)'(DEPTH);
      return l;
   endfunction

   // Memory is frozen for the whole job, including DONE.
   assign rf_we       = wr_en && (state_q == ST_IDLE);
   assign len_clamped = clamp_len(len);

   pe_pair_rf #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_rf (
      .clk       (clk),
      .rst       (rst),
      .we_i      (rf_we),
      .waddr_i   (wr_addr),
      .wifmap_i  (wr_ifmap),
      .wfilter_i (wr_filter),
      .raddr_i   (idx_q[ADDR_W-1:0]),
      .rifmap_o  (rd_ifmap),
      .rfilter_o (rd_filter)
   );

   // Outputs are decoded from the next state so each registered output lines
   // up with the state it belongs to.
   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      idx_d       = idx_q;
      pe_rst_d    = 1'b0;
      pe_en_d     = 1'b0;
      pe_ifmap_d  = '0;
      pe_filter_d = '0;
      res_valid_d = 1'b0;
      res_data_d  = res_data_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               len_d = len_clamped;
               idx_d = '0;
               if (len_clamped == '0) begin
                  state_d     = ST_DONE;
                  res_data_d  = '0;
                  res_valid_d = 1'b1;
               end else begin
                  state_d  = ST_CLEAR;
                  pe_rst_d = 1'b1;
               end
            end
         end
         ST_CLEAR, ST_STREAM: begin
            if (idx_q == len_q) begin
               state_d = ST_DRAIN;
            end else begin
               state_d     = ST_STREAM;
               pe_en_d     = 1'b1;
               pe_ifmap_d  = rd_ifmap;
               pe_filter_d = rd_filter;
               idx_d       = idx_q + {{ADDR_W{1'b0}}, 1'b1};
            end
         end
         ST_DRAIN: begin
            // The PE absorbed the last pair on the edge that entered DRAIN.
            state_d     = ST_DONE;
            res_data_d  = pe_psum;
            res_valid_d = 1'b1;
         end
         ST_DONE: begin
            if (res_ready) state_d = ST_IDLE;
            else res_valid_d = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         len_q       <= '0;
         idx_q       <= '0;
         busy_q      <= 1'b0;
         pe_rst_q    <= 1'b1;
         pe_en_q     <= 1'b0;
         pe_ifmap_q  <= '0;
         pe_filter_q <= '0;
         res_valid_q <= 1'b0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         idx_q       <= idx_d;
         busy_q      <= busy_d;
         pe_rst_q    <= pe_rst_d;
         pe_en_q     <= pe_en_d;
         pe_ifmap_q  <= pe_ifmap_d;
         pe_filter_q <= pe_filter_d;
         res_valid_q <= res_valid_d;
         res_data_q  <= res_data_d;
      end
   end

   assign busy      = busy_q;
   assign pe_rst    = pe_rst_q;
   assign pe_en     = pe_en_q;
   assign pe_ifmap  = pe_ifmap_q;
   assign pe_filter = pe_filter_q;
   assign res_valid = res_valid_q;
   assign res_data  = res_data_q;

endmodule

// File: tb/tb_pe_feeder.sv
// Bench for pe_feeder driving a behavioural MAC PE: table of jobs, randomized
// jobs against a sum-of-products reference, and reset / write-blocking sequences.
module tb_pe_feeder;

   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en;
   logic [2:0]  wr_addr;
   logic [15:0] wr_ifmap, wr_filter;
   logic [3:0]  len;
   logic        start;
   logic        busy, pe_rst, pe_en, res_valid, res_ready;
   logic [15:0] pe_ifmap, pe_filter, pe_psum, res_data;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] ref_i [8];
   logic [15:0] ref_f [8];

   always #5 clk = ~clk;

   pe_feeder #(.DATA_W(16), .DEPTH(8), .ADDR_W(3)) dut (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_ifmap  (wr_ifmap),
      .wr_filter (wr_filter),
      .len       (len),
      .start     (start),
      .busy      (busy),
      .pe_rst    (pe_rst),
      .pe_en     (pe_en),
      .pe_ifmap  (pe_ifmap),
      .pe_filter (pe_filter),
      .pe_psum   (pe_psum),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data)
   );

   // MAC processing element: clear has priority, psum wraps mod 2^16.
   logic [31:0] pe_prod;
   assign pe_prod = pe_ifmap * pe_filter;
   always @(posedge clk or negedge rst) begin
      if (!rst)        pe_psum <= '0;
      else if (pe_rst) pe_psum <= '0;
      else if (pe_en)  pe_psum <= pe_psum + pe_prod[15:0];
   end

   typedef struct packed {
      logic [3:0]        len;
      logic [7:0][15:0]  ifm;
      logic [7:0][15:0]  flt;
      logic [15:0]       exp;
      logic [3:0]        dly;
   } vec_t;

   vec_t tbl [8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_pair(input logic [2:0] a, input logic [15:0] fi, input logic [15:0] ff);
      wr_en = 1'b1; wr_addr = a; wr_ifmap = fi; wr_filter = ff;
      step();
      wr_en = 1'b0;
      ref_i[a] = fi;
      ref_f[a] = ff;
   endtask

   function automatic int clamp(input logic [3:0] l);
      return (int'(l) > 8) ? 8 : int'(l);
   endfunction

   function automatic logic [15:0] ref_result(input logic [3:0] l);
      logic [15:0] s = '0;
      logic [31:0] p;
      for (int i = 0; i < clamp(l); i++) begin
         p = ref_i[i] * ref_f[i];
         s = s + p[15:0];
      end
      return s;
   endfunction

   task automatic run_job(input string nm, input logic [3:0] l, input logic [15:0] exp,
                          input int dly, input bit co_wr, input logic [2:0] ca,
                          input logic [15:0] cai, input logic [15:0] caf, input bit bsy_wr);
      int edges, k, nrst, cl;
      cl = clamp(l);
      start = 1'b1; len = l;
      if (co_wr) begin
         wr_en = 1'b1; wr_addr = ca; wr_ifmap = cai; wr_filter = caf;
      end
      step();
      start = 1'b0; wr_en = 1'b0;
      edges = 1; k = 0; nrst = 0;
      while (!res_valid && edges < 40) begin
         if (pe_rst) nrst++;
         if (pe_en) begin
            if (k < 8) begin
               check($sformatf("%s ifmap[%0d]", nm, k), pe_ifmap, ref_i[k]);
               check($sformatf("%s filter[%0d]", nm, k), pe_filter, ref_f[k]);
            end
            k++;
         end
         if (bsy_wr && edges == 1) begin
            check({nm, " busy before blocked write"}, busy, 1);
            wr_en = 1'b1; wr_addr = 3'd0; wr_ifmap = 16'd7; wr_filter = 16'd9;
         end else begin
            wr_en = 1'b0;
         end
         step();
         edges++;
      end
      wr_en = 1'b0;
      check({nm, " res_valid seen"}, res_valid, 1);
      check({nm, " latency edges"}, edges, (cl == 0) ? 1 : cl + 3);
      check({nm, " pe_en cycles"}, k, cl);
      check({nm, " pe_rst pulses"}, nrst, (cl > 0) ? 1 : 0);
      check({nm, " res_data"}, res_data, exp);
      for (int j = 0; j < dly; j++) begin
         check($sformatf("%s hold valid %0d", nm, j), res_valid, 1);
         check($sformatf("%s hold data %0d", nm, j), res_data, exp);
         check($sformatf("%s hold busy %0d", nm, j), busy, 1);
         start = (j == 1);
         step();
         start = 1'b0;
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check({nm, " busy after accept"}, busy, 0);
      check({nm, " valid after accept"}, res_valid, 0);
      step();
      check({nm, " stays idle"}, busy, 0);
   endtask

   task automatic run_vec(input string nm, input vec_t v);
      for (int i = 0; i < 8; i++) write_pair(3'(i), v.ifm[i], v.flt[i]);
      run_job(nm, v.len, v.exp, int'(v.dly), 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);
   endtask

   initial begin
      logic [15:0] e;
      logic [3:0]  rl;
      bit          stuck;
      rst = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_ifmap = '0; wr_filter = '0;
      len = '0; start = 1'b0; res_ready = 1'b0;
      for (int i = 0; i < 8; i++) begin ref_i[i] = '0; ref_f[i] = '0; end

      for (int i = 0; i < 8; i++) tbl[i] = '0;
      tbl[0].len = 4'd3; tbl[0].exp = 16'd44;
      tbl[0].ifm[0] = 16'd3; tbl[0].flt[0] = 16'd4;
      tbl[0].ifm[1] = 16'd5; tbl[0].flt[1] = 16'd6;
      tbl[0].ifm[2] = 16'd1; tbl[0].flt[2] = 16'd2;
      tbl[1] = tbl[0]; tbl[1].len = 4'd0; tbl[1].exp = 16'd0;
      tbl[2] = tbl[0]; tbl[2].dly = 4'd5;
      tbl[3].len = 4'd1; tbl[3].exp = 16'd0;
      tbl[3].ifm[0] = 16'd256; tbl[3].flt[0] = 16'd256;
      tbl[4].len = 4'd1; tbl[4].exp = 16'd65535;
      tbl[4].ifm[0] = 16'd255; tbl[4].flt[0] = 16'd257;
      for (int i = 0; i < 8; i++) begin
         tbl[5].ifm[i] = 16'd1; tbl[5].flt[i] = 16'd1;
         tbl[7].ifm[i] = 16'(i + 1); tbl[7].flt[i] = 16'(i + 2);
      end
      tbl[5].len = 4'd9; tbl[5].exp = 16'd8;
      tbl[6] = tbl[5]; tbl[6].len = 4'd15; tbl[6].dly = 4'd2;
      tbl[7].len = 4'd8; tbl[7].exp = 16'd240; tbl[7].dly = 4'd1;

      // Reset state
      step(); step();
      check("rst busy", busy, 0);
      check("rst pe_rst", pe_rst, 1);
      check("rst pe_en", pe_en, 0);
      check("rst pe_ifmap", pe_ifmap, 0);
      check("rst res_valid", res_valid, 0);
      check("rst res_data", res_data, 0);
      rst = 1'b1;
      step();
      check("idle pe_rst", pe_rst, 0);

      for (int t = 0; t < 8; t++) run_vec($sformatf("vec%0d", t), tbl[t]);

      // Write coinciding with start must be used by the job
      ref_i[1] = 16'd10; ref_f[1] = 16'd11;
      e = ref_result(4'd8);
      run_job("cowrite", 4'd8, e, 0, 1'b1, 3'd1, 16'd10, 16'd11, 1'b0);

      // Randomized jobs against the sum-of-products reference
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 8; i++) begin
            if (r[0]) write_pair(3'(i), 16'($urandom), 16'($urandom));
            else write_pair(3'(i), 16'($urandom_range(0, 300)), 16'($urandom_range(0, 300)));
         end
         rl = 4'($urandom_range(0, 15));
         run_job($sformatf("rand%0d", r), rl, ref_result(rl), $urandom_range(0, 3),
                 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);
      end

      // Asynchronous reset in the middle of streaming
      write_pair(3'd0, 16'd3, 16'd4);
      write_pair(3'd1, 16'd5, 16'd6);
      write_pair(3'd2, 16'd1, 16'd2);
      start = 1'b1; len = 4'd3;
      step();
      start = 1'b0;
      step(); step();
      check("pre-reset pe_en", pe_en, 1);
      #1 rst = 1'b0;
      #1;
      check("async busy", busy, 0);
      check("async pe_rst", pe_rst, 1);
      check("async pe_en", pe_en, 0);
      check("async pe_ifmap", pe_ifmap, 0);
      check("async pe_filter", pe_filter, 0);
      check("async res_valid", res_valid, 0);
      step(); step();
      rst = 1'b1;
      for (int i = 0; i < 8; i++) begin ref_i[i] = '0; ref_f[i] = '0; end
      stuck = 1'b0;
      for (int i = 0; i < 6; i++) begin
         if (res_valid || busy) stuck = 1'b1;
         step();
      end
      check("no result after abort", stuck, 0);
      run_job("readback busywr", 4'd1, 16'd0, 0, 1'b0, 3'd0, 16'd0, 16'd0, 1'b1);
      run_job("after busywr", 4'd1, 16'd0, 0, 1'b0, 3'd0, 16'd0, 16'd0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
